// File: rtl/mr_idecode.sv
// mr_idecode: RV32I decode stage. Decodes the fetched word into op class, register indices and a
// sign-extended immediate, and holds the result in one pipeline register for EX (1-cycle latency).
// Backpressure: id_ready drops while EX holds a packet, on a scoreboard RAW hazard, or on a WB redirect.
// Ports: clk/rst; inst/inst_pc/inst_valid -> id_ready (fetch side); wb_pc_valid (flush), wb_rd/wb_rd_valid
// (retire); rs1_adr/rs2_adr (comb. regfile read addresses); ex_valid/ex_ready and ex_* packet (EX side).
module mr_idecode #(
  parameter int NREGS      = 32,
  parameter bit SCOREBOARD = 1'b1,
  localparam int XLEN      = 32,
  localparam int IMAXLEN   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IMAXLEN-1:0] inst,
  input  logic [XLEN-1:0]    inst_pc,
  input  logic               inst_valid,
  output logic               id_ready,
  input  logic               wb_pc_valid,
  input  logic [4:0]         wb_rd,
  input  logic               wb_rd_valid,
  output logic [4:0]         rs1_adr,
  output logic [4:0]         rs2_adr,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_pc,
  output logic [3:0]         ex_op,
  output logic [2:0]         ex_funct3,
  output logic               ex_alt,
  output logic [4:0]         ex_rd,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [XLEN-1:0]    ex_imm
);

  localparam logic [3:0] OP_LUI = 4'd0, OP_AUIPC = 4'd1, OP_JAL = 4'd2, OP_JALR = 4'd3,
                         OP_BRANCH = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_ALUI = 4'd7,
                         OP_ALU = 4'd8, OP_FENCE = 4'd9, OP_SYSTEM = 4'd10, OP_ILLEGAL = 4'd15;

  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  logic [6:0] f7;
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  assign rs1_adr = rs1;
  assign rs2_adr = rs2;

  // Immediate formats, all sign-extended from inst[31] except U.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_wr, dec_use1, dec_use2, dec_ill;
  logic            f7_bad;

  assign f7_bad = (f7 != 7'h00) && (f7 != 7'h20);

  always_comb begin
    dec_op   = OP_ILLEGAL;
    dec_imm  = '0;
    dec_wr   = 1'b0;
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_ill  = 1'b0;
    // Every known opcode ends in 2'b11, so a compressed/non-32-bit word lands in default.
    case (inst[6:0])
      7'b0110111: begin dec_op = OP_LUI;   dec_wr = 1'b1; dec_imm = imm_u; end
      7'b0010111: begin dec_op = OP_AUIPC; dec_wr = 1'b1; dec_imm = imm_u; end
      7'b1101111: begin dec_op = OP_JAL;   dec_wr = 1'b1; dec_imm = imm_j; end
      7'b1100111: begin
        dec_op = OP_JALR; dec_wr = 1'b1; dec_use1 = 1'b1; dec_imm = imm_i;
        dec_ill = (f3 != 3'd0);
      end
      7'b1100011: begin
        dec_op = OP_BRANCH; dec_use1 = 1'b1; dec_use2 = 1'b1; dec_imm = imm_b;
        dec_ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'b0000011: begin
        dec_op = OP_LOAD; dec_wr = 1'b1; dec_use1 = 1'b1; dec_imm = imm_i;
        dec_ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0100011: begin
        dec_op = OP_STORE; dec_use1 = 1'b1; dec_use2 = 1'b1; dec_imm = imm_s;
        dec_ill = (f3 > 3'd2);
      end
      7'b0010011: begin
        dec_op = OP_ALUI; dec_wr = 1'b1; dec_use1 = 1'b1; dec_imm = imm_i;
        // Only the shift-immediates carry a funct7 field.
        dec_ill = ((f3 == 3'd1) || (f3 == 3'd5)) && f7_bad;
      end
      7'b0110011: begin
        dec_op = OP_ALU; dec_wr = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1;
        dec_ill = f7_bad;
      end
      7'b0001111: begin dec_op = OP_FENCE;  dec_use1 = 1'b1; dec_imm = imm_i; end
      7'b1110011: begin dec_op = OP_SYSTEM; dec_wr = 1'b1; dec_use1 = 1'b1; dec_imm = imm_i; end
      default:    dec_ill = 1'b1;
    endcase
    if ((dec_use1 && int'(rs1) >= NREGS) || (dec_use2 && int'(rs2) >= NREGS) ||
        (dec_wr && int'(rd) >= NREGS))
      dec_ill = 1'b1;
    // Illegal words carry no register usage, so they never stall and never mark the scoreboard.
    if (dec_ill) begin
      dec_op   = OP_ILLEGAL;
      dec_imm  = '0;
      dec_wr   = 1'b0;
      dec_use1 = 1'b0;
      dec_use2 = 1'b0;
    end
  end

  // Scoreboard, widened to 32 entries for lookup so any 5-bit index is safe.
  logic [NREGS-1:0] sb_q;
  logic [31:0]      sb_wide, sb_d;

  always_comb begin
    sb_wide = '0;
    sb_wide[NREGS-1:0] = sb_q;
  end

  logic advance, hazard, xfer;
  assign advance  = !ex_valid || ex_ready;
  assign hazard   = SCOREBOARD && inst_valid &&
                    ((dec_use1 && sb_wide[rs1]) || (dec_use2 && sb_wide[rs2]));
  assign id_ready = advance && !hazard && !wb_pc_valid;
  assign xfer     = inst_valid && id_ready;

  always_comb begin
    sb_d = sb_wide;
    if (wb_pc_valid) begin
      sb_d = '0;
    end else begin
      if (wb_rd_valid) sb_d[wb_rd] = 1'b0;
      // Applied after the clear so a new writer of the same index wins.
      if (xfer && dec_wr && rd != 5'd0) sb_d[rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d[NREGS-1:0];
  end

  // Pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_op     <= '0;
      ex_funct3 <= '0;
      ex_alt    <= 1'b0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_imm    <= '0;
    end else if (wb_pc_valid) begin
      ex_valid <= 1'b0;
    end else if (xfer) begin
      ex_valid  <= 1'b1;
      ex_pc     <= inst_pc;
      ex_op     <= dec_op;
      ex_funct3 <= f3;
      ex_alt    <= inst[30];
      ex_rd     <= dec_wr ? rd : 5'd0;
      ex_rs1    <= rs1;
      ex_rs2    <= rs2;
      ex_imm    <= dec_imm;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mr_idecode.sv
module tb_mr_idecode;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, wb_pc_valid, wb_rd_valid, ex_ready;
  logic [4:0]  wb_rd;

  logic        id_ready, ex_valid, ex_alt;
  logic [4:0]  rs1_adr, rs2_adr, ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_pc, ex_imm;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;

  logic        id_ready_b, ex_valid_b, ex_alt_b;
  logic [4:0]  rs1_adr_b, rs2_adr_b, ex_rd_b, ex_rs1_b, ex_rs2_b;
  logic [31:0] ex_pc_b, ex_imm_b;
  logic [3:0]  ex_op_b;
  logic [2:0]  ex_funct3_b;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mr_idecode #(.NREGS(32), .SCOREBOARD(1'b1)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .id_ready(id_ready), .wb_pc_valid(wb_pc_valid), .wb_rd(wb_rd), .wb_rd_valid(wb_rd_valid),
    .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm)
  );

  mr_idecode #(.NREGS(16), .SCOREBOARD(1'b1)) dut16 (
    .clk(clk), .rst(rst), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .id_ready(id_ready_b), .wb_pc_valid(wb_pc_valid), .wb_rd(wb_rd), .wb_rd_valid(wb_rd_valid),
    .rs1_adr(rs1_adr_b), .rs2_adr(rs2_adr_b), .ex_valid(ex_valid_b), .ex_ready(ex_ready),
    .ex_pc(ex_pc_b), .ex_op(ex_op_b), .ex_funct3(ex_funct3_b), .ex_alt(ex_alt_b), .ex_rd(ex_rd_b),
    .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .ex_imm(ex_imm_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w, input logic [31:0] p);
    inst       = w;
    inst_pc    = p;
    inst_valid = 1'b1;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inst = '0; inst_pc = '0; inst_valid = 1'b0;
    wb_pc_valid = 1'b0; wb_rd = '0; wb_rd_valid = 1'b0; ex_ready = 1'b1;
    #1;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ex_pc",    ex_pc, 32'd0);
    chk("rst_ex_op",    {28'b0, ex_op}, 32'd0);
    chk("rst_ex_imm",   ex_imm, 32'd0);
    chk("rst_ex_rd",    {27'b0, ex_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // addi x1,x0,5
    present(32'h00500093, 32'h100);
    chk("addi_id_ready", {31'b0, id_ready}, 32'd1);
    chk("addi_rs2_adr",  {27'b0, rs2_adr}, 32'd5);
    tick();
    inst_valid = 1'b0;
    chk("addi_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("addi_ex_op",    {28'b0, ex_op}, 32'd7);
    chk("addi_ex_rd",    {27'b0, ex_rd}, 32'd1);
    chk("addi_ex_rs1",   {27'b0, ex_rs1}, 32'd0);
    chk("addi_ex_imm",   ex_imm, 32'd5);
    chk("addi_ex_pc",    ex_pc, 32'h100);
    chk("addi_sb",       dut.sb_q, 32'h2);

    // retire x1, bubble drains
    wb_rd = 5'd1; wb_rd_valid = 1'b1;
    tick();
    wb_rd_valid = 1'b0;
    chk("bubble_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("retire_sb",       dut.sb_q, 32'h0);

    // sw x2,-4(x1)
    present(32'hFE20AE23, 32'h104);
    chk("sw_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("sw_ex_op",  {28'b0, ex_op}, 32'd6);
    chk("sw_ex_rs1", {27'b0, ex_rs1}, 32'd1);
    chk("sw_ex_rs2", {27'b0, ex_rs2}, 32'd2);
    chk("sw_ex_rd",  {27'b0, ex_rd}, 32'd0);
    chk("sw_ex_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_f3",     {29'b0, ex_funct3}, 32'd2);
    chk("sw_sb",     dut.sb_q, 32'h0);

    // addi x1 then add x3,x1,x2: RAW stall until x1 retires
    present(32'h00500093, 32'h108);
    tick();
    present(32'h002081B3, 32'h10C);
    chk("raw_stall0", {31'b0, id_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'b0, id_ready}, 32'd0);
    chk("raw_bubble", {31'b0, ex_valid}, 32'd0);
    wb_rd = 5'd1; wb_rd_valid = 1'b1;
    #1;
    chk("raw_stall_clr_cycle", {31'b0, id_ready}, 32'd0);
    tick();
    wb_rd_valid = 1'b0;
    #1;
    chk("raw_released", {31'b0, id_ready}, 32'd1);
    tick();
    inst_valid = 1'b0;
    chk("add_ex_op",  {28'b0, ex_op}, 32'd8);
    chk("add_ex_rd",  {27'b0, ex_rd}, 32'd3);
    chk("add_ex_pc",  ex_pc, 32'h10C);
    chk("add_ex_imm", ex_imm, 32'd0);
    chk("add_sb",     dut.sb_q, 32'h8);

    // EX backpressure for 5 cycles, next inst waiting (addi x4,x0,9)
    ex_ready = 1'b0;
    present(32'h00900213, 32'h110);
    chk("hold_id_ready", {31'b0, id_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("hold_ex_pc",    ex_pc, 32'h10C);
      chk("hold_ex_op",    {28'b0, ex_op}, 32'd8);
      chk("hold_id_ready", {31'b0, id_ready}, 32'd0);
    end
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("nobubble_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("nobubble_ex_pc",    ex_pc, 32'h110);
    chk("nobubble_ex_rd",    {27'b0, ex_rd}, 32'd4);
    chk("nobubble_ex_imm",   ex_imm, 32'd9);
    chk("nobubble_sb",       dut.sb_q, 32'h18);

    // addi x1 while x4 retires -> sb = {x3,x1}
    wb_rd = 5'd4; wb_rd_valid = 1'b1;
    present(32'h00500093, 32'h114);
    tick();
    wb_rd_valid = 1'b0;
    chk("pre_flush_sb",       dut.sb_q, 32'h0000000A);
    chk("pre_flush_ex_valid", {31'b0, ex_valid}, 32'd1);

    // redirect with EX stalled
    ex_ready = 1'b0; wb_pc_valid = 1'b1;
    present(32'h00900213, 32'h118);
    chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
    tick();
    wb_pc_valid = 1'b0;
    chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_sb",       dut.sb_q, 32'h0);
    ex_ready = 1'b1;
    #1;
    chk("post_flush_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("post_flush_ex_pc",    ex_pc, 32'h118);
    chk("post_flush_ex_valid", {31'b0, ex_valid}, 32'd1);

    // mul (funct7=1) reading pending x4: illegal, not stalled
    present(32'h022201B3, 32'h11C);
    chk("mul_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("mul_ex_op", {28'b0, ex_op}, 32'd15);
    chk("mul_ex_rd", {27'b0, ex_rd}, 32'd0);

    present(32'hFFFFFFFF, 32'h120);
    tick();
    chk("ones_ex_op", {28'b0, ex_op}, 32'd15);
    chk("ones_ex_rd", {27'b0, ex_rd}, 32'd0);

    // beq x0,x0,-8
    present(32'hFE000CE3, 32'h124);
    tick();
    chk("beq_ex_op",  {28'b0, ex_op}, 32'd4);
    chk("beq_ex_imm", ex_imm, 32'hFFFFFFF8);
    chk("beq_ex_rd",  {27'b0, ex_rd}, 32'd0);

    // lui x5,0x12345
    present(32'h123452B7, 32'h128);
    tick();
    chk("lui_ex_op",  {28'b0, ex_op}, 32'd0);
    chk("lui_ex_imm", ex_imm, 32'h12345000);
    chk("lui_ex_rd",  {27'b0, ex_rd}, 32'd5);

    // jal x0,+16
    present(32'h0100006F, 32'h12C);
    tick();
    chk("jal_ex_op",  {28'b0, ex_op}, 32'd2);
    chk("jal_ex_imm", ex_imm, 32'h10);

    // addi x17,x0,1: legal with 32 regs, illegal with 16
    present(32'h00100893, 32'h130);
    tick();
    chk("x17_ex_op",     {28'b0, ex_op}, 32'd7);
    chk("x17_ex_rd",     {27'b0, ex_rd}, 32'd17);
    chk("x17_rv32e_op",  {28'b0, ex_op_b}, 32'd15);
    chk("x17_rv32e_rd",  {27'b0, ex_rd_b}, 32'd0);
    chk("x17_rv32e_vld", {31'b0, ex_valid_b}, 32'd1);

    // addi x5,x0,7 then stall and assert reset between edges
    present(32'h00700293, 32'h134);
    tick();
    inst_valid = 1'b0;
    ex_ready   = 1'b0;
    tick();
    chk("stall_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("stall_ex_pc",    ex_pc, 32'h134);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ex_valid",   {31'b0, ex_valid}, 32'd0);
    chk("async_rst_ex_pc",      ex_pc, 32'd0);
    chk("async_rst_ex_valid16", {31'b0, ex_valid_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
